// File: rtl/rwm_arbiter_pkg.sv
// Shared definitions for the frame-memory arbiter: port indices, FSM states,
// read-return tag layout and small port-index helpers.
package rwm_arbiter_pkg;

    localparam int unsigned NUM_PORTS = 3;

    typedef logic [1:0] port_t;

    localparam port_t PORT_CAM = 2'd0;
    localparam port_t PORT_GS  = 2'd1;
    localparam port_t PORT_FLT = 2'd2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // One entry of the read-return pipeline: which port a read beat belongs to.
    typedef struct packed {
        logic  valid;
        port_t port;
    } rtag_t;

    function automatic port_t onehot_to_port(input logic [NUM_PORTS-1:0] oh);
        if (oh[2]) begin
            return PORT_FLT;
        end
        if (oh[1]) begin
            return PORT_GS;
        end
        return PORT_CAM;
    endfunction

    function automatic logic [NUM_PORTS-1:0] port_to_onehot(input port_t p);
        return NUM_PORTS'(1) << p;
    endfunction

endpackage

// File: rtl/rwm_arbiter_if.sv
// Requester-side and memory-side bus of the frame-memory arbiter.
// slave is the arbiter's view; master is the environment (requesters + RAM).
interface rwm_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) ();
    import rwm_arbiter_pkg::*;

    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        rw;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS-1:0]        grant;
    logic [NUM_PORTS-1:0]        pause;
    logic [NUM_PORTS-1:0]        rvalid;
    logic [DATA_W-1:0]           rdata;

    logic                        mem_en;
    logic                        mem_rw;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    modport slave (
        input  req, rw, addr, wdata, mem_rdata,
        output grant, pause, rvalid, rdata, mem_en, mem_rw, mem_addr, mem_wdata
    );

    modport master (
        output req, rw, addr, wdata, mem_rdata,
        input  grant, pause, rvalid, rdata, mem_en, mem_rw, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rwm_arbiter_rr_pick3.sv
// Combinational round-robin picker for three requesters: grants the first
// requesting port after last_owner, searching cyclically 0 -> 1 -> 2 -> 0.
module rr_pick3
    import rwm_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_t                last_owner,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 valid
);

    port_t p0;
    port_t p1;
    port_t p2;

    // Order the candidates starting just after last_owner, then take the first requester.
    always_comb begin
        case (last_owner)
            PORT_CAM: begin p0 = PORT_GS;  p1 = PORT_FLT; p2 = PORT_CAM; end
            PORT_GS:  begin p0 = PORT_FLT; p1 = PORT_CAM; p2 = PORT_GS;  end
            default:  begin p0 = PORT_CAM; p1 = PORT_GS;  p2 = PORT_FLT; end
        endcase
        grant = '0;
        if (req[p0]) begin
            grant[p0] = 1'b1;
        end else if (req[p1]) begin
            grant[p1] = 1'b1;
        end else if (req[p2]) begin
            grant[p2] = 1'b1;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/rwm_arbiter.sv
// Time-multiplexes one single-port frame memory between three requesters.
// Bounded round-robin bursts, per-port pause, and read data routed back to
// the issuing port through a tag pipeline matching the memory read latency.
module rwm_arbiter
    import rwm_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst,
    rwm_arbiter_if.slave  bus
);

    localparam logic [7:0]  BURST_LAST = 8'(BURST_LEN - 1);
    localparam int unsigned TAG_W      = $bits(rtag_t);
    localparam int unsigned SR_W       = RD_LAT * TAG_W;

    state_t               state;
    logic [NUM_PORTS-1:0] grant_q;
    port_t                last_owner;
    logic [7:0]           beat_cnt;
    logic [SR_W-1:0]      tag_sr;

    logic [NUM_PORTS-1:0] beat_vec;
    logic                 beat;
    port_t                owner;
    port_t                pick_last;
    logic [NUM_PORTS-1:0] pick_grant;
    logic                 pick_valid;
    logic                 burst_end;
    rtag_t                new_tag;
    rtag_t                out_tag;

    logic [ADDR_W-1:0]    port_addr  [NUM_PORTS];
    logic [DATA_W-1:0]    port_wdata [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_split
        assign port_addr[g]  = bus.addr[g*ADDR_W +: ADDR_W];
        assign port_wdata[g] = bus.wdata[g*DATA_W +: DATA_W];
    end

    assign beat_vec = grant_q & bus.req;
    assign beat     = |beat_vec;
    assign owner    = onehot_to_port(grant_q);

    // In BURST the picker only matters at burst end, where the owner becomes
    // last_owner on that same edge; feeding the owner directly lets the next
    // grant be computed without an idle gap.
    assign pick_last = (state == ST_BURST) ? owner : last_owner;
    assign burst_end = (state == ST_BURST) && (!beat || beat_cnt == BURST_LAST);

    rr_pick3 u_pick (
        .req        (bus.req),
        .last_owner (pick_last),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // Grant / burst sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            last_owner <= PORT_FLT;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q  <= pick_grant;
                        beat_cnt <= '0;
                        state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (burst_end) begin
                        last_owner <= owner;
                        beat_cnt   <= '0;
                        if (pick_valid) begin
                            grant_q <= pick_grant;
                        end else begin
                            grant_q <= '0;
                            state   <= ST_IDLE;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory request mux: driven from the owner's port only while it issues a beat.
    always_comb begin
        bus.mem_en    = beat;
        bus.mem_rw    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (beat) begin
            bus.mem_rw    = bus.rw[owner];
            bus.mem_addr  = port_addr[owner];
            bus.mem_wdata = port_wdata[owner];
        end
    end

    // Tag describing this cycle's beat for the read-return pipeline.
    always_comb begin
        new_tag.valid = beat & ~bus.rw[owner];
        new_tag.port  = owner;
    end

    // Read-return tag shift pipeline, RD_LAT entries deep.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_sr <= '0;
        end else begin
            tag_sr <= (tag_sr << TAG_W) | SR_W'(new_tag);
        end
    end

    assign out_tag    = rtag_t'(tag_sr[SR_W-1 -: TAG_W]);
    assign bus.rvalid = out_tag.valid ? port_to_onehot(out_tag.port) : '0;
    assign bus.rdata  = out_tag.valid ? bus.mem_rdata : '0;
    assign bus.grant  = grant_q;
    assign bus.pause  = bus.req & ~grant_q;

endmodule

// File: tb/tb_rwm_arbiter.sv
// Self-checking bench for rwm_arbiter: a transaction-level model of the
// arbitration rules predicts every output each cycle.
module tb_rwm_arbiter;

    localparam int BL_A = 4;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    int n_checks = 0;
    int n_fail   = 0;

    rwm_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus_a ();
    rwm_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus_b ();

    rwm_arbiter #(.ADDR_W(16), .DATA_W(8), .BURST_LEN(BL_A), .RD_LAT(1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    rwm_arbiter #(.ADDR_W(16), .DATA_W(8), .BURST_LEN(16), .RD_LAT(1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    logic [15:0] s_addr  [3];
    logic [7:0]  s_wdata [3];
    assign bus_a.addr  = {s_addr[2], s_addr[1], s_addr[0]};
    assign bus_a.wdata = {s_wdata[2], s_wdata[1], s_wdata[0]};

    // Frame RAM for dut_a: one-cycle read latency, pattern reloaded on reset.
    logic [7:0] ram_a [256];
    always @(posedge clk) begin
        if (rst_a) begin
            for (int i = 0; i < 256; i++) ram_a[i] <= 8'(i + 'h90);
        end else if (bus_a.mem_en) begin
            if (bus_a.mem_rw) ram_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
            else              bus_a.mem_rdata <= ram_a[bus_a.mem_addr[7:0]];
        end
    end

    // Trivial RAM for dut_b (only its grants are examined).
    always @(posedge clk) bus_b.mem_rdata <= bus_b.mem_addr[7:0];

    // Reference model state: who owns the memory, beats served, pending read return.
    int         m_owner;
    int         m_last;
    int         m_cnt;
    int         m_rv_port;
    logic [7:0] m_rv_data;
    logic [7:0] m_mem [256];

    function automatic int pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            int p;
            p = (last + k) % 3;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    function automatic void model_update();
        logic [2:0] r;
        int a;
        r = bus_a.req;
        if (rst_a) begin
            m_owner = -1; m_last = 2; m_cnt = 0; m_rv_port = -1;
            for (int i = 0; i < 256; i++) m_mem[i] = 8'(i + 'h90);
            return;
        end
        m_rv_port = -1;
        if (m_owner < 0) begin
            if (r != 3'b000) begin
                m_owner = pick(r, m_last);
                m_cnt   = 0;
            end
        end else if (!r[m_owner]) begin
            m_last  = m_owner;
            m_owner = pick(r, m_last);
            m_cnt   = 0;
        end else begin
            a = int'(s_addr[m_owner][7:0]);
            if (bus_a.rw[m_owner]) begin
                m_mem[a] = s_wdata[m_owner];
            end else begin
                m_rv_port = m_owner;
                m_rv_data = m_mem[a];
            end
            m_cnt++;
            if (m_cnt == BL_A) begin
                m_last  = m_owner;
                m_owner = pick(r, m_last);
                m_cnt   = 0;
            end
        end
    endfunction

    function automatic logic [42:0] exp_vec();
        logic [2:0]  r, g, rv;
        logic        beat, mrw;
        logic [15:0] maddr;
        logic [7:0]  mwd, rd;
        r = bus_a.req;
        g = '0; rv = '0; beat = 1'b0; mrw = 1'b0; maddr = '0; mwd = '0; rd = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            beat       = r[m_owner];
        end
        if (beat) begin
            mrw   = bus_a.rw[m_owner];
            maddr = s_addr[m_owner];
            mwd   = s_wdata[m_owner];
        end
        if (m_rv_port >= 0) begin
            rv[m_rv_port] = 1'b1;
            rd            = m_rv_data;
        end
        return {g, r & ~g, rv, rd, beat, mrw, maddr, mwd};
    endfunction

    function automatic logic [42:0] act_vec();
        return {bus_a.grant, bus_a.pause, bus_a.rvalid, bus_a.rdata,
                bus_a.mem_en, bus_a.mem_rw, bus_a.mem_addr, bus_a.mem_wdata};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic pulse_reset();
        rst_a = 1'b1;
        bus_a.req = 3'b000;
        tick();
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        bus_a.req = 3'b111;
        bus_a.rw = 3'($urandom);
        for (int i = 0; i < 3; i++) begin
            s_addr[i] = 16'($urandom); s_wdata[i] = 8'($urandom);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_outputs c%0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            n_checks++;
            if (bus_a.grant !== 3'b000 || bus_a.pause !== 3'b111) begin
                n_fail++;
                $display("FAIL reset_grant_pause c%0d: got grant=%b pause=%b expected 000/111", c, bus_a.grant, bus_a.pause);
            end
        end
        tick();
    endtask

    task automatic test_priority();
        logic [2:0] eg;
        rst_a = 1'b0;
        bus_a.req = 3'b111;
        for (int c = 0; c < 25; c++) begin
            bus_a.rw = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                s_addr[i] = 16'($urandom); s_wdata[i] = 8'($urandom);
            end
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL priority_outputs c%0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            eg = (c == 0) ? 3'b000 : 3'(1 << (((c - 1) / BL_A) % 3));
            n_checks++;
            if (bus_a.grant !== eg || bus_a.mem_en !== (c != 0)) begin
                n_fail++;
                $display("FAIL priority_order c%0d: got grant=%b mem_en=%b expected %b/%b", c, bus_a.grant, bus_a.mem_en, eg, c != 0);
            end
            tick();
        end
    endtask

    task automatic test_early_release();
        int n = 0;
        int en_cnt = 0;
        int rv_cnt = 0;
        logic [7:0] got_d [3];
        logic [7:0] want_d [3];
        want_d[0] = 8'hA0; want_d[1] = 8'hA1; want_d[2] = 8'hA2;
        pulse_reset();
        bus_a.rw = 3'b000;
        for (int c = 0; c < 8; c++) begin
            s_addr[1]    = 16'h0010 + 16'(n);
            s_wdata[1]   = 8'($urandom);
            bus_a.req    = (n < 3) ? 3'b010 : 3'b000;
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL early_release_outputs c%0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            if (bus_a.mem_en === 1'b1) en_cnt++;
            if (bus_a.rvalid[1] === 1'b1) begin
                if (rv_cnt < 3) got_d[rv_cnt] = bus_a.rdata;
                rv_cnt++;
            end
            if (bus_a.req[1] && m_owner == 1) n++;
            tick();
        end
        n_checks++;
        if (en_cnt != 3 || rv_cnt != 3) begin
            n_fail++;
            $display("FAIL early_release_counts: got mem_en=%0d rvalid=%0d expected 3/3", en_cnt, rv_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (got_d[k] !== want_d[k]) begin
                n_fail++;
                $display("FAIL early_release_data%0d: got %h expected %h", k, got_d[k], want_d[k]);
            end
        end
    endtask

    task automatic test_handover();
        pulse_reset();
        bus_a.rw   = 3'b001;
        s_addr[0]  = 16'h0040;
        s_wdata[0] = 8'h5A;
        for (int c = 0; c < 8; c++) begin
            s_addr[2] = 16'h0020 + 16'(c);
            bus_a.req = (c == 0) ? 3'b100 : (c < 5) ? 3'b101 : (c < 7) ? 3'b001 : 3'b000;
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL handover_outputs c%0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            if (bus_a.rvalid[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL handover_rvalid0 c%0d: got %b expected 0", c, bus_a.rvalid[0]);
            end
            n_checks++;
            if (c == 5) begin
                n_checks++;
                if (bus_a.rvalid !== 3'b100 || bus_a.grant !== 3'b001 || bus_a.mem_en !== 1'b1 || bus_a.mem_rw !== 1'b1) begin
                    n_fail++;
                    $display("FAIL handover_edge: got rvalid=%b grant=%b en=%b rw=%b expected 100/001/1/1",
                             bus_a.rvalid, bus_a.grant, bus_a.mem_en, bus_a.mem_rw);
                end
            end
            tick();
        end
    endtask

    task automatic test_pause();
        logic seen2 = 1'b0;
        pulse_reset();
        bus_a.rw   = 3'b001;
        s_addr[0]  = 16'h0030;
        s_addr[2]  = 16'h0077;
        for (int c = 0; c < 8; c++) begin
            s_wdata[0] = 8'($urandom);
            bus_a.req  = (c == 0) ? 3'b001 : 3'b101;
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL pause_outputs c%0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            if (bus_a.grant[2] === 1'b1) seen2 = 1'b1;
            if (c >= 1 && !seen2) begin
                n_checks++;
                if (bus_a.pause !== 3'b100) begin
                    n_fail++;
                    $display("FAIL pause_vector c%0d: got %b expected 100", c, bus_a.pause);
                end
                n_checks++;
                if (bus_a.mem_en === 1'b1 && bus_a.mem_addr === 16'h0077) begin
                    n_fail++;
                    $display("FAIL pause_leak c%0d: got port-2 address %h on memory expected none", c, bus_a.mem_addr);
                end
            end
            tick();
        end
        n_checks++;
        if (seen2 !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_grant2: got no grant[2] expected grant within 8 cycles");
        end
    endtask

    task automatic test_reset_mid_burst();
        pulse_reset();
        bus_a.rw = 3'b000;
        for (int c = 0; c < 8; c++) begin
            rst_a     = (c == 5);
            bus_a.req = (c <= 5) ? 3'b001 : 3'b010;
            s_addr[0] = 16'h0050 + 16'(c);
            s_addr[1] = 16'h0060;
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rst_mid_outputs c%0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            if (c == 6) begin
                n_checks++;
                if (bus_a.grant !== 3'b000 || bus_a.mem_en !== 1'b0 || bus_a.rvalid !== 3'b000) begin
                    n_fail++;
                    $display("FAIL rst_mid_abort: got grant=%b en=%b rvalid=%b expected 000/0/000",
                             bus_a.grant, bus_a.mem_en, bus_a.rvalid);
                end
            end
            if (c == 7) begin
                n_checks++;
                if (bus_a.grant !== 3'b010) begin
                    n_fail++;
                    $display("FAIL rst_mid_regrant: got %b expected 010", bus_a.grant);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int c = 0; c < 300; c++) begin
            rst_a = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) bus_a.req[i] = ~bus_a.req[i];
                bus_a.rw[i] = 1'($urandom);
                s_addr[i]   = 16'($urandom);
                s_wdata[i]  = 8'($urandom);
            end
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_outputs c%0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            tick();
        end
        rst_a = 1'b0;
        bus_a.req = 3'b000;
    endtask

    task automatic test_fairness();
        int waited;
        logic got;
        rst_b = 1'b1;
        bus_b.req = 3'b000;
        tick();
        rst_b = 1'b0;
        bus_b.req = 3'b011;
        for (int rep = 0; rep < 4; rep++) begin
            repeat ($urandom_range(0, 40)) tick();
            bus_b.req = 3'b111;
            got = 1'b0;
            waited = 0;
            for (int k = 1; k <= 60 && !got; k++) begin
                tick();
                @(negedge clk);
                if (bus_b.grant[2] === 1'b1) begin
                    got = 1'b1;
                    waited = k;
                end
            end
            n_checks++;
            if (!got || waited > 34) begin
                n_fail++;
                $display("FAIL fairness rep%0d: got wait=%0d granted=%b expected grant within 34 cycles", rep, waited, got);
            end
            bus_b.req = 3'b011;
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.req = 3'b000;
        bus_a.rw  = 3'b000;
        bus_b.req = 3'b000;
        bus_b.rw  = 3'b000;
        bus_b.addr  = '0;
        bus_b.wdata = '0;
        for (int i = 0; i < 3; i++) begin
            s_addr[i] = '0; s_wdata[i] = '0;
        end
        m_owner = -1; m_last = 2; m_cnt = 0; m_rv_port = -1; m_rv_data = '0;

        test_reset();
        test_priority();
        test_early_release();
        test_handover();
        test_pause();
        test_reset_mid_burst();
        test_random();
        test_fairness();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
